// File: rtl/if_stream.sv
// Instruction-fetch stage of the LoongArch-32 5-stage pipeline.
// Pre-IF computes the next PC and issues it to a synchronous instruction
// SRAM. The IF stage holds one fetched instruction and offers it to decode.
// A branch redirect from decode squashes the wrong-path fetch. The returned
// word is buffered while decode stalls, so the SRAM output can change freely.
module if_stream #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ID_allowin,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        IF_to_ID_valid,
    output logic [31:0] IF_pc_out,
    output logic [31:0] IF_inst_out,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
);

    // The SRAM always answers one cycle after the request.
    localparam logic IF_READY_GO = 1'b1;

    // Pre-IF stage: next fetch address
    logic [31:0] nextpc_p0;

    // IF stage state
    logic        if_vld_p1;
    logic [31:0] if_pc_p1;
    logic        br_pend_p1;
    logic [31:0] pend_target_p1;
    logic        ibuf_vld_p1;
    logic [31:0] ibuf_p1;

    logic        if_allowin;

    // IF accepts a new fetch when it is empty or when decode takes its contents.
    assign if_allowin = !if_vld_p1 | (IF_READY_GO & ID_allowin);

    // Next-PC selection: a live redirect wins over a deferred redirect,
    // which wins over sequential fetch. The +4 wraps at 32 bits.
    always_comb begin
        nextpc_p0 = if_pc_p1 + 32'd4;
        if (br_taken) begin
            nextpc_p0 = br_target;
        end else if (br_pend_p1) begin
            nextpc_p0 = pend_target_p1;
        end
    end

    // A request goes out only when IF can take the word next cycle.
    assign inst_sram_en    = !reset & if_allowin;
    assign inst_sram_addr  = nextpc_p0;
    assign inst_sram_we    = 4'b0000;
    assign inst_sram_wdata = 32'h0000_0000;

    // Pre-IF -> IF boundary: fetch, squash on redirect, or buffer while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_vld_p1      <= 1'b0;
            if_pc_p1       <= RESET_PC - 32'd4;
            br_pend_p1     <= 1'b0;
            pend_target_p1 <= 32'h0000_0000;
            ibuf_vld_p1    <= 1'b0;
            ibuf_p1        <= 32'h0000_0000;
        end else if (if_allowin) begin
            // The fetch just issued consumes any redirect.
            if_vld_p1   <= 1'b1;
            if_pc_p1    <= nextpc_p0;
            ibuf_vld_p1 <= 1'b0;
            br_pend_p1  <= 1'b0;
        end else if (br_taken) begin
            // No fetch slot this cycle. Drop the wrong-path word and
            // remember the target so the empty IF fetches it next cycle.
            if_vld_p1      <= 1'b0;
            br_pend_p1     <= 1'b1;
            pend_target_p1 <= br_target;
            ibuf_vld_p1    <= 1'b0;
        end else if (if_vld_p1 && !ibuf_vld_p1) begin
            // First stall cycle: the SRAM word is only good now.
            ibuf_p1     <= inst_sram_rdata;
            ibuf_vld_p1 <= 1'b1;
        end
    end

    // IF -> ID boundary: never offer the instruction that a redirect kills.
    assign IF_to_ID_valid = if_vld_p1 & IF_READY_GO & !br_taken;
    assign IF_pc_out      = if_pc_p1;
    assign IF_inst_out    = ibuf_vld_p1 ? ibuf_p1 : inst_sram_rdata;

endmodule

// File: tb/tb_if_stream.sv
// Self-checking bench for if_stream.
// The SRAM model returns each fetch address as its data word, so PC and
// instruction checks use the same expected value.
module tb_if_stream;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    logic        clk;
    logic        reset;
    logic        ID_allowin;
    logic        br_taken;
    logic [31:0] br_target;
    logic        IF_to_ID_valid;
    logic [31:0] IF_pc_out;
    logic [31:0] IF_inst_out;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_fetch[$];
    logic [31:0] exp_offer[$];

    logic garbage;
    logic watch_00c;
    int   offers_00c;

    if_stream #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .ID_allowin     (ID_allowin),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .IF_to_ID_valid (IF_to_ID_valid),
        .IF_pc_out      (IF_pc_out),
        .IF_inst_out    (IF_inst_out),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_we   (inst_sram_we),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM: data = address, or random junk when idle and garbage is set.
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= inst_sram_addr;
        else if (garbage) inst_sram_rdata <= $urandom;
    end

    // Count any offer of 1c00000c to decode while it is being watched.
    always @(negedge clk) begin
        if (watch_00c && !reset && IF_to_ID_valid && IF_pc_out == 32'h1c00_000c)
            offers_00c <= offers_00c + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) begin
            tick();
            @(negedge clk);
            n_cmp++; if (IF_to_ID_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", IF_to_ID_valid); end
            n_cmp++; if (inst_sram_en !== 1'b0) begin n_bad++; $display("FAIL reset_en: got %b want 0", inst_sram_en); end
            n_cmp++; if (IF_pc_out !== RESET_PC - 32'd4) begin n_bad++; $display("FAIL reset_pc: got %h want %h", IF_pc_out, RESET_PC - 32'd4); end
            n_cmp++; if (inst_sram_we !== 4'b0 || inst_sram_wdata !== 32'b0) begin n_bad++; $display("FAIL reset_tie: got we=%h wdata=%h want 0", inst_sram_we, inst_sram_wdata); end
        end
    endtask

    task automatic test_sequential();
        logic [31:0] a, p;
        for (int i = 0; i < 3; i++) exp_fetch.push_back(RESET_PC + 32'(4 * i));
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = exp_fetch.pop_front();
            n_cmp++; if (inst_sram_en !== 1'b1) begin n_bad++; $display("FAIL seq_en[%0d]: got %b want 1", i, inst_sram_en); end
            n_cmp++; if (inst_sram_addr !== a) begin n_bad++; $display("FAIL seq_addr[%0d]: got %h want %h", i, inst_sram_addr, a); end
            if (i == 0) begin
                n_cmp++; if (IF_to_ID_valid !== 1'b0) begin n_bad++; $display("FAIL seq_first_valid: got %b want 0", IF_to_ID_valid); end
            end else begin
                p = exp_offer.pop_front();
                n_cmp++; if (IF_to_ID_valid !== 1'b1) begin n_bad++; $display("FAIL seq_valid[%0d]: got %b want 1", i, IF_to_ID_valid); end
                n_cmp++; if (IF_pc_out !== p) begin n_bad++; $display("FAIL seq_pc[%0d]: got %h want %h", i, IF_pc_out, p); end
                n_cmp++; if (IF_inst_out !== p) begin n_bad++; $display("FAIL seq_inst[%0d]: got %h want %h", i, IF_inst_out, p); end
            end
            exp_offer.push_back(a);
            tick();
        end
    endtask

    task automatic test_stall();
        logic [31:0] p;
        ID_allowin = 1'b0;
        garbage    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (inst_sram_en !== 1'b0) begin n_bad++; $display("FAIL stall_en[%0d]: got %b want 0", i, inst_sram_en); end
            n_cmp++; if (IF_pc_out !== 32'h1c00_0008) begin n_bad++; $display("FAIL stall_pc[%0d]: got %h want 1c000008", i, IF_pc_out); end
            n_cmp++; if (IF_inst_out !== 32'h1c00_0008) begin n_bad++; $display("FAIL stall_inst[%0d]: got %h want 1c000008", i, IF_inst_out); end
            n_cmp++; if (IF_to_ID_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d]: got %b want 1", i, IF_to_ID_valid); end
            tick();
        end
        ID_allowin = 1'b1;
        garbage    = 1'b0;
        @(negedge clk);
        p = exp_offer.pop_front();
        n_cmp++; if (IF_inst_out !== p) begin n_bad++; $display("FAIL stall_release_inst: got %h want %h", IF_inst_out, p); end
        n_cmp++; if (inst_sram_en !== 1'b1) begin n_bad++; $display("FAIL stall_release_en: got %b want 1", inst_sram_en); end
        n_cmp++; if (inst_sram_addr !== 32'h1c00_000c) begin n_bad++; $display("FAIL stall_release_addr: got %h want 1c00000c", inst_sram_addr); end
        tick();
    endtask

    task automatic test_redirect_stalled();
        watch_00c  = 1'b1;
        ID_allowin = 1'b0;
        br_taken   = 1'b1;
        br_target  = 32'h1c00_0200;
        @(negedge clk);
        n_cmp++; if (IF_to_ID_valid !== 1'b0) begin n_bad++; $display("FAIL rds_squash_valid: got %b want 0", IF_to_ID_valid); end
        n_cmp++; if (inst_sram_en !== 1'b0) begin n_bad++; $display("FAIL rds_stall_en: got %b want 0", inst_sram_en); end
        tick();
        br_taken = 1'b0;
        @(negedge clk);
        n_cmp++; if (IF_to_ID_valid !== 1'b0) begin n_bad++; $display("FAIL rds_bubble_valid: got %b want 0", IF_to_ID_valid); end
        n_cmp++; if (inst_sram_en !== 1'b1) begin n_bad++; $display("FAIL rds_pend_en: got %b want 1", inst_sram_en); end
        n_cmp++; if (inst_sram_addr !== 32'h1c00_0200) begin n_bad++; $display("FAIL rds_pend_addr: got %h want 1c000200", inst_sram_addr); end
        tick();
        @(negedge clk);
        n_cmp++; if (IF_pc_out !== 32'h1c00_0200) begin n_bad++; $display("FAIL rds_pc: got %h want 1c000200", IF_pc_out); end
        n_cmp++; if (IF_inst_out !== 32'h1c00_0200) begin n_bad++; $display("FAIL rds_inst: got %h want 1c000200", IF_inst_out); end
        n_cmp++; if (IF_to_ID_valid !== 1'b1) begin n_bad++; $display("FAIL rds_valid: got %b want 1", IF_to_ID_valid); end
        tick();
        ID_allowin = 1'b1;
    endtask

    task automatic test_redirect();
        br_taken  = 1'b1;
        br_target = 32'h1c00_0100;
        @(negedge clk);
        n_cmp++; if (IF_to_ID_valid !== 1'b0) begin n_bad++; $display("FAIL rd_valid: got %b want 0", IF_to_ID_valid); end
        n_cmp++; if (inst_sram_en !== 1'b1) begin n_bad++; $display("FAIL rd_en: got %b want 1", inst_sram_en); end
        n_cmp++; if (inst_sram_addr !== 32'h1c00_0100) begin n_bad++; $display("FAIL rd_addr: got %h want 1c000100", inst_sram_addr); end
        tick();
        br_taken = 1'b0;
        @(negedge clk);
        n_cmp++; if (IF_pc_out !== 32'h1c00_0100) begin n_bad++; $display("FAIL rd_pc: got %h want 1c000100", IF_pc_out); end
        n_cmp++; if (IF_inst_out !== 32'h1c00_0100) begin n_bad++; $display("FAIL rd_inst: got %h want 1c000100", IF_inst_out); end
        n_cmp++; if (IF_to_ID_valid !== 1'b1) begin n_bad++; $display("FAIL rd_next_valid: got %b want 1", IF_to_ID_valid); end
        n_cmp++; if (inst_sram_addr !== 32'h1c00_0104) begin n_bad++; $display("FAIL rd_next_addr: got %h want 1c000104", inst_sram_addr); end
        watch_00c = 1'b0;
        n_cmp++; if (offers_00c !== 0) begin n_bad++; $display("FAIL rd_no_00c: got %0d offers want 0", offers_00c); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, p;
        exp_fetch.delete();
        exp_offer.delete();
        exp_offer.push_back(32'h1c00_0104);
        for (int i = 0; i < 8; i++) exp_fetch.push_back(32'h1c00_0108 + 32'(4 * i));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            p = exp_offer.pop_front();
            a = exp_fetch.pop_front();
            n_cmp++; if (IF_to_ID_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, IF_to_ID_valid); end
            n_cmp++; if (IF_pc_out !== p || IF_inst_out !== p) begin n_bad++; $display("FAIL b2b_out[%0d]: got pc=%h inst=%h want %h", i, IF_pc_out, IF_inst_out, p); end
            n_cmp++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== a) begin n_bad++; $display("FAIL b2b_fetch[%0d]: got en=%b addr=%h want 1/%h", i, inst_sram_en, inst_sram_addr, a); end
            exp_offer.push_back(a);
            tick();
        end
    endtask

    task automatic test_wrap();
        br_taken  = 1'b1;
        br_target = 32'hffff_fffc;
        @(negedge clk);
        n_cmp++; if (inst_sram_addr !== 32'hffff_fffc) begin n_bad++; $display("FAIL wrap_redirect_addr: got %h want fffffffc", inst_sram_addr); end
        tick();
        br_taken = 1'b0;
        @(negedge clk);
        n_cmp++; if (IF_pc_out !== 32'hffff_fffc) begin n_bad++; $display("FAIL wrap_pc: got %h want fffffffc", IF_pc_out); end
        n_cmp++; if (inst_sram_addr !== 32'h0000_0000 || inst_sram_en !== 1'b1) begin n_bad++; $display("FAIL wrap_addr: got en=%b addr=%h want 1/00000000", inst_sram_en, inst_sram_addr); end
        tick();
        @(negedge clk);
        n_cmp++; if (IF_pc_out !== 32'h0000_0000 || IF_inst_out !== 32'h0000_0000) begin n_bad++; $display("FAIL wrap_out: got pc=%h inst=%h want 0", IF_pc_out, IF_inst_out); end
        tick();
    endtask

    task automatic test_reset_mid();
        ID_allowin = 1'b0;
        @(negedge clk);
        n_cmp++; if (inst_sram_en !== 1'b0) begin n_bad++; $display("FAIL rm_stall_en: got %b want 0", inst_sram_en); end
        tick();
        br_taken  = 1'b1;
        br_target = 32'h1c00_0300;
        tick();
        br_taken = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        n_cmp++; if (inst_sram_en !== 1'b0 || IF_to_ID_valid !== 1'b0) begin n_bad++; $display("FAIL rm_in_reset: got en=%b valid=%b want 0/0", inst_sram_en, IF_to_ID_valid); end
        tick();
        @(negedge clk);
        n_cmp++; if (IF_pc_out !== RESET_PC - 32'd4) begin n_bad++; $display("FAIL rm_pc: got %h want %h", IF_pc_out, RESET_PC - 32'd4); end
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== RESET_PC) begin n_bad++; $display("FAIL rm_first_fetch: got en=%b addr=%h want 1/%h", inst_sram_en, inst_sram_addr, RESET_PC); end
        n_cmp++; if (IF_to_ID_valid !== 1'b0) begin n_bad++; $display("FAIL rm_first_valid: got %b want 0", IF_to_ID_valid); end
        tick();
        @(negedge clk);
        n_cmp++; if (IF_pc_out !== RESET_PC || IF_inst_out !== RESET_PC) begin n_bad++; $display("FAIL rm_out: got pc=%h inst=%h want %h", IF_pc_out, IF_inst_out, RESET_PC); end
        n_cmp++; if (IF_to_ID_valid !== 1'b1) begin n_bad++; $display("FAIL rm_valid: got %b want 1", IF_to_ID_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset           = 1'b1;
        ID_allowin      = 1'b1;
        br_taken        = 1'b0;
        br_target       = 32'h0;
        garbage         = 1'b0;
        watch_00c       = 1'b0;
        offers_00c      = 0;
        inst_sram_rdata = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stalled();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
